// File: rtl/chicken_race_core.sv
// chicken_race_core
// Turn-and-movement engine for the chicken race board game. It holds every
// player's track position and lap count, checks a flipped picture against
// the track tile ahead of the current player, advances on a match (hopping
// over occupied tiles) and passes the turn on a miss. A player that
// completes LAPS laps is declared the winner.
//
// Ports:
//   clk          in  : clock, all state changes on the rising edge
//   rst          in  : synchronous active-low reset
//   start        in  : one-cycle strobe, start a new game (highest priority)
//   num_players  in  : player count, sampled on start, clamped to 2..MAX_PLAYERS
//   flip_valid   in  : one-cycle strobe, a tile was flipped (used only in PLAY)
//   flip_code    in  : picture on the flipped tile
//   track_code   in  : picture of the track tile at tile_addr (combinational ROM)
//   tile_addr    out : (pos[turn] + 1) mod TRACK_LEN
//   turn         out : index of the current player
//   cur_pos      out : pos[turn]
//   busy         out : high while a flip is being resolved
//   match        out : one-cycle pulse on a matching flip (first ADV cycle)
//   turn_end     out : one-cycle pulse when the turn passes (NEXT cycle)
//   winner_valid out : high while the game is over
//   winner       out : winning player, meaningful while winner_valid is high
module chicken_race_core #(
  parameter int MAX_PLAYERS = 4,
  parameter int TRACK_LEN   = 24,
  parameter int TILE_W      = 4,
  parameter int LAPS        = 1,
  localparam int PW = $clog2(MAX_PLAYERS),
  localparam int NW = $clog2(MAX_PLAYERS + 1),
  localparam int AW = $clog2(TRACK_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NW-1:0]     num_players,
  input  logic              flip_valid,
  input  logic [TILE_W-1:0] flip_code,
  input  logic [TILE_W-1:0] track_code,
  output logic [AW-1:0]     tile_addr,
  output logic [PW-1:0]     turn,
  output logic [AW-1:0]     cur_pos,
  output logic              busy,
  output logic              match,
  output logic              turn_end,
  output logic              winner_valid,
  output logic [PW-1:0]     winner
);

  // Arrays are sized to the full turn index range so r_turn can never
  // address outside them, even for non-power-of-two MAX_PLAYERS.
  localparam int NSLOT = 1 << PW;
  localparam int LW    = $clog2(LAPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_CHECK,
    S_ADV,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_pos [NSLOT];
  logic [LW-1:0]     r_lap [NSLOT];
  logic [NW-1:0]     r_np;
  logic [PW-1:0]     r_turn;
  logic [PW-1:0]     r_winner;
  logic [TILE_W-1:0] r_code;
  logic [AW-1:0]     r_cand;
  logic              r_match;
  logic              r_turn_end;
  logic              r_winner_valid;

  logic [NW-1:0]     w_np;
  logic              w_occupied;
  logic [AW-1:0]     w_cur_pos;
  logic [AW-1:0]     w_addr;
  logic              w_wrap;
  logic [LW-1:0]     w_lap_next;
  logic [PW-1:0]     w_turn_next;

  function automatic logic [AW-1:0] inc_mod(input logic [AW-1:0] a);
    return (a == AW'(TRACK_LEN - 1)) ? '0 : a + AW'(1);
  endfunction

  always_comb begin
    w_np = num_players;
    if (num_players < NW'(2)) begin
      w_np = NW'(2);
    end else if (num_players > NW'(MAX_PLAYERS)) begin
      w_np = NW'(MAX_PLAYERS);
    end
  end

  // Another active player already stands on the candidate tile.
  always_comb begin
    w_occupied = 1'b0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      if ((NW'(i) < r_np) && (PW'(i) != r_turn) && (r_pos[i] == r_cand)) begin
        w_occupied = 1'b1;
      end
    end
  end

  assign w_cur_pos   = r_pos[r_turn];
  assign w_addr      = inc_mod(w_cur_pos);
  // Landing below the old position means the move crossed tile 0.
  assign w_wrap      = (r_cand < w_cur_pos);
  assign w_lap_next  = (w_wrap && (r_lap[r_turn] != LW'(LAPS))) ?
                       r_lap[r_turn] + LW'(1) : r_lap[r_turn];
  assign w_turn_next = ((NW'(r_turn) + NW'(1)) == r_np) ? '0 : r_turn + PW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_turn         <= '0;
      r_np           <= NW'(2);
      r_code         <= '0;
      r_cand         <= '0;
      r_match        <= 1'b0;
      r_turn_end     <= 1'b0;
      r_winner_valid <= 1'b0;
      r_winner       <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        r_pos[i] <= '0;
        r_lap[i] <= '0;
      end
    end else begin
      r_match    <= 1'b0;
      r_turn_end <= 1'b0;
      if (start) begin
        // A new game overrides whatever was in flight, including a commit.
        r_np           <= w_np;
        r_turn         <= '0;
        r_winner_valid <= 1'b0;
        r_state        <= S_PLAY;
        for (int i = 0; i < NSLOT; i++) begin
          r_pos[i] <= (NW'(i) < w_np) ? AW'(i) : '0;
          r_lap[i] <= '0;
        end
      end else begin
        case (r_state)
          S_IDLE: ;
          S_PLAY: begin
            if (flip_valid) begin
              r_code  <= flip_code;
              r_state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (r_code == track_code) begin
              r_cand  <= w_addr;
              r_match <= 1'b1;
              r_state <= S_ADV;
            end else begin
              r_turn_end <= 1'b1;
              r_state    <= S_NEXT;
            end
          end
          S_ADV: begin
            // One candidate tile per cycle; a free tile always exists.
            if (w_occupied) begin
              r_cand <= inc_mod(r_cand);
            end else begin
              r_pos[r_turn] <= r_cand;
              r_lap[r_turn] <= w_lap_next;
              if (w_lap_next == LW'(LAPS)) begin
                r_winner       <= r_turn;
                r_winner_valid <= 1'b1;
                r_state        <= S_DONE;
              end else begin
                r_state <= S_PLAY;
              end
            end
          end
          S_NEXT: begin
            r_turn  <= w_turn_next;
            r_state <= S_PLAY;
          end
          S_DONE: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tile_addr    = w_addr;
  assign turn         = r_turn;
  assign cur_pos      = w_cur_pos;
  assign busy         = (r_state == S_CHECK) || (r_state == S_ADV) || (r_state == S_NEXT);
  assign match        = r_match;
  assign turn_end     = r_turn_end;
  assign winner_valid = r_winner_valid;
  assign winner       = r_winner;

endmodule

// File: tb/tb_chicken_race_core.sv
module tb_chicken_race_core;

  localparam int MP = 4;
  localparam int TL = 24;
  localparam int LP = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] num_players;
  logic       flip_valid;
  logic [3:0] flip_code;
  logic [3:0] track_code;
  logic [4:0] tile_addr;
  logic [1:0] turn;
  logic [4:0] cur_pos;
  logic       busy;
  logic       match;
  logic       turn_end;
  logic       winner_valid;
  logic [1:0] winner;

  logic [3:0] rom [32];
  assign track_code = rom[tile_addr];

  always #5 clk = ~clk;

  chicken_race_core #(
    .MAX_PLAYERS(MP),
    .TRACK_LEN  (TL),
    .TILE_W     (4),
    .LAPS       (LP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_players (num_players),
    .flip_valid  (flip_valid),
    .flip_code   (flip_code),
    .track_code  (track_code),
    .tile_addr   (tile_addr),
    .turn        (turn),
    .cur_pos     (cur_pos),
    .busy        (busy),
    .match       (match),
    .turn_end    (turn_end),
    .winner_valid(winner_valid),
    .winner      (winner)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_match;
    int cyc;
    int turn;
  } pulse_t;

  typedef struct {
    int cyc;
    int turn;
    int pos;
    bit wv;
    int winner;
  } post_t;

  pulse_t pulse_q[$];
  post_t  post_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: game state in plain integers.
  int mnp;
  int mturn;
  int mpos [MP];
  int mlap [MP];
  bit mlive;

  function automatic bit occupied(input int c);
    for (int i = 0; i < mnp; i++)
      if (i != mturn && mpos[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_start(input int n);
    mnp = (n < 2) ? 2 : ((n > MP) ? MP : n);
    for (int i = 0; i < MP; i++) begin
      mpos[i] = (i < mnp) ? i : 0;
      mlap[i] = 0;
    end
    mturn = 0;
    mlive = 1'b1;
  endtask

  // Monitor: pops expectations when the DUT shows a pulse or finishes a flip.
  logic   prev_busy = 1'b0;
  pulse_t mp_p;
  post_t  mp_q;
  always @(negedge clk) begin
    if (match || turn_end) begin
      if (pulse_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: match=%0d turn_end=%0d required none (cycle %0d)",
                 match, turn_end, cyc);
      end else begin
        mp_p = pulse_q.pop_front();
        chk("pulse_kind", {match, turn_end}, mp_p.is_match ? 2 : 1);
        chk("pulse_cycle", cyc, mp_p.cyc);
        chk("pulse_turn", turn, mp_p.turn);
      end
    end
    if (rst && prev_busy && !busy) begin
      if (post_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: busy fell with nothing expected (cycle %0d)", cyc);
      end else begin
        mp_q = post_q.pop_front();
        chk("done_cycle", cyc, mp_q.cyc);
        chk("done_turn", turn, mp_q.turn);
        chk("done_cur_pos", cur_pos, mp_q.pos);
        chk("done_tile_addr", tile_addr, (mp_q.pos + 1) % TL);
        chk("done_winner_valid", winner_valid, mp_q.wv);
        if (mp_q.wv) chk("done_winner", winner, mp_q.winner);
      end
    end
    prev_busy <= busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((pulse_q.size() != 0 || post_q.size() != 0) && n < 60) begin
      step();
      n++;
    end
    if (pulse_q.size() != 0 || post_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d pulses and %0d completions still outstanding",
               pulse_q.size(), post_q.size());
      pulse_q.delete();
      post_q.delete();
    end
    repeat (2) step();
  endtask

  task automatic do_start(input int n);
    start       = 1'b1;
    num_players = 3'(n);
    step();
    start = 1'b0;
    model_start(n);
    chk("start_turn", turn, 0);
    chk("start_cur_pos", cur_pos, 0);
    chk("start_tile_addr", tile_addr, 1);
    chk("start_busy", busy, 0);
    chk("start_winner_valid", winner_valid, 0);
  endtask

  // Issue one flip (held for 'hold' edges; the extra edges fall in CHECK,
  // ADV or NEXT and must be ignored) and record what the game should do.
  task automatic do_flip(input bit want, input int hold);
    int a, code, k, p, c, s;
    bit win;
    a    = (mpos[mturn] + 1) % TL;
    code = want ? int'(rom[a]) : (int'(rom[a]) + 1 + int'($urandom_range(0, 14))) % 16;
    flip_valid = 1'b1;
    flip_code  = 4'(code);
    k = cyc + 1;
    if (mlive) begin
      if (code == int'(rom[a])) begin
        p = mpos[mturn];
        c = (p + 1) % TL;
        s = 0;
        while (occupied(c)) begin
          c = (c + 1) % TL;
          s++;
        end
        if (c < p && mlap[mturn] < LP) mlap[mturn]++;
        mpos[mturn] = c;
        win = (mlap[mturn] == LP);
        pulse_q.push_back('{1'b1, k + 1, mturn});
        post_q.push_back('{k + 2 + s, mturn, c, win, mturn});
        if (win) mlive = 1'b0;
      end else begin
        pulse_q.push_back('{1'b0, k + 1, mturn});
        mturn = (mturn + 1) % mnp;
        post_q.push_back('{k + 2, mturn, mpos[mturn], 1'b0, 0});
      end
    end
    repeat (hold) step();
    flip_valid = 1'b0;
    wait_quiet();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_turn"}, turn, 0);
    chk({tag, "_cur_pos"}, cur_pos, 0);
    chk({tag, "_tile_addr"}, tile_addr, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_turn_end"}, turn_end, 0);
    chk({tag, "_winner_valid"}, winner_valid, 0);
    chk({tag, "_winner"}, winner, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, nflips, wpos, wturn;
    for (int i = 0; i < 32; i++) rom[i] = 4'($urandom_range(0, 15));
    rst         = 1'b0;
    start       = 1'b0;
    num_players = '0;
    flip_valid  = 1'b0;
    flip_code   = '0;
    mlive       = 1'b0;
    mnp         = 2;
    mturn       = 0;
    for (int i = 0; i < MP; i++) begin
      mpos[i] = 0;
      mlap[i] = 0;
    end
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b1;
    step();

    // Fresh game with three players, misses rotate the turn 0->1->2->0.
    do_start(3);
    repeat (3) do_flip(1'b0, 1);
    // P0 matches tile 1 and hops over P1 and P2 to tile 3.
    do_flip(1'b1, 1);
    chk("skip_land_pos", cur_pos, 3);
    chk("skip_keeps_turn", turn, 0);

    // Player-count clamping, observed through turn rotation.
    do_start(0);
    repeat (2) do_flip(1'b0, 1);
    do_start(7);
    repeat (4) do_flip(1'b0, 2);

    // Randomized games played to a win, with flips ignored after the win.
    for (int g = 0; g < 4; g++) begin
      do_start($urandom_range(0, 7));
      nflips = 0;
      while (mlive && nflips < 400) begin
        do_flip($urandom_range(0, 9) < 7, $urandom_range(1, 3));
        nflips++;
      end
      wturn = mturn;
      wpos  = mpos[mturn];
      chk("game_winner_valid", winner_valid, 1);
      chk("game_winner", winner, wturn);
      do_flip(1'b1, 1);
      do_flip(1'b0, 1);
      chk("done_hold_winner_valid", winner_valid, 1);
      chk("done_hold_winner", winner, wturn);
      chk("done_hold_pos", cur_pos, wpos);
      chk("done_hold_busy", busy, 0);
    end

    // Start arriving while ADV is resolving a match: the new game wins.
    do_start(3);
    flip_valid = 1'b1;
    flip_code  = rom[1];
    k = cyc + 1;
    pulse_q.push_back('{1'b1, k + 1, 0});
    post_q.push_back('{k + 2, 0, 0, 1'b0, 0});
    step();
    flip_valid = 1'b0;
    step();
    start       = 1'b1;
    num_players = 3'd3;
    step();
    start = 1'b0;
    model_start(3);
    wait_quiet();
    chk("start_in_adv_pos", cur_pos, 0);
    do_flip(1'b0, 1);

    // Reset during ADV abandons the move and silences further pulses.
    do_start(3);
    flip_valid = 1'b1;
    flip_code  = rom[1];
    k = cyc + 1;
    pulse_q.push_back('{1'b1, k + 1, 0});
    step();
    flip_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk_all_zero("mid_reset");
    step();
    rst   = 1'b1;
    mlive = 1'b0;
    mturn = 0;
    for (int i = 0; i < MP; i++) begin
      mpos[i] = 0;
      mlap[i] = 0;
    end
    do_flip(1'b1, 1);
    repeat (5) step();
    chk_all_zero("after_reset");
    chk("outstanding_expectations", pulse_q.size() + post_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
